// File: rtl/block_byte_sequencer_if.sv
// Block-in / byte-out stream bundle for block_byte_sequencer.
// The master drives blocks and consumes bytes; the slave is the sequencer.
interface block_byte_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_byte;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, in_block, flush, out_ready,
        input  in_ready, out_valid, out_byte, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_block, flush, out_ready,
        output in_ready, out_valid, out_byte, out_idx, out_last, busy
    );
endinterface

// File: rtl/block_byte_sequencer.sv
// Serialises a 128-bit block into 16 bytes, word 0 first, MSB first within a word.
// Define SEQ_DOUBLE_BUF_EN to add a hold register that removes the inter-block bubble.
module block_byte_sequencer (
    input logic                   clk,
    input logic                   rst,
    block_byte_sequencer_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] cur;
    logic [127:0] cur_nxt;
    logic [3:0]   idx;
    logic [3:0]   idx_nxt;
    logic         in_ready;
    logic         out_valid;
    logic         in_hs;
    logic         out_hs;
    logic         last_hs;
    logic [6:0]   bit_lo;

`ifdef SEQ_DOUBLE_BUF_EN
    logic [127:0] hold;
    logic [127:0] hold_nxt;
    logic         hold_valid;
    logic         hold_valid_nxt;

    assign in_ready = !rst && !bus.flush && !hold_valid;
`else
    assign in_ready = !rst && !bus.flush && (state == IDLE);
`endif

    assign out_valid = (state == SEND);
    assign in_hs     = bus.in_valid && in_ready;
    assign out_hs    = out_valid && bus.out_ready;
    assign last_hs   = out_hs && (idx == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cur   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            idx   <= idx_nxt;
        end
    end

`ifdef SEQ_DOUBLE_BUF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else begin
            hold       <= hold_nxt;
            hold_valid <= hold_valid_nxt;
        end
    end
`endif

    // Flush wins over any coincident handshake; an output transfer on that edge is simply consumed.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        idx_nxt   = idx;
`ifdef SEQ_DOUBLE_BUF_EN
        hold_nxt       = hold;
        hold_valid_nxt = hold_valid;
`endif
        if (bus.flush) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
`ifdef SEQ_DOUBLE_BUF_EN
            hold_valid_nxt = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        cur_nxt   = bus.in_block;
                        idx_nxt   = '0;
                        state_nxt = SEND;
                    end
                end
                SEND: begin
                    if (out_hs && !last_hs) begin
                        idx_nxt = idx + 4'd1;
                    end
`ifdef SEQ_DOUBLE_BUF_EN
                    // in_ready is low whenever hold is full, so in_hs here implies an empty hold.
                    if (last_hs) begin
                        idx_nxt = '0;
                        if (hold_valid) begin
                            cur_nxt        = hold;
                            hold_valid_nxt = 1'b0;
                        end else if (in_hs) begin
                            cur_nxt = bus.in_block;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (in_hs) begin
                        hold_nxt       = bus.in_block;
                        hold_valid_nxt = 1'b1;
                    end
`else
                    if (last_hs) begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end
`endif
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Byte idx sits at bits 127-8*idx down to 120-8*idx, i.e. its low bit is 8*(15-idx).
    assign bit_lo       = {4'd15 - idx, 3'b000};
    assign bus.out_byte = cur[bit_lo +: 8];
    assign bus.out_idx  = idx;
    assign bus.out_last = out_valid && (idx == 4'd15);
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready;
`ifdef SEQ_DOUBLE_BUF_EN
    assign bus.busy = out_valid || hold_valid;
`else
    assign bus.busy = out_valid;
`endif

    // A stalled byte must stay put until it is taken or flushed.
    property p_stall_stable;
        @(posedge clk) disable iff (rst)
        (out_valid && !bus.out_ready && !bus.flush) |=> (out_valid && $stable(idx) && $stable(cur));
    endproperty
    assert property (p_stall_stable);

    property p_flush_blocks_input;
        @(posedge clk) disable iff (rst)
        bus.flush |-> !in_ready;
    endproperty
    assert property (p_flush_blocks_input);
endmodule

// File: tb/tb_block_byte_sequencer.sv
// Scoreboard bench for block_byte_sequencer: the driver queues expected bytes, a monitor checks them.
// Define SEQ_DOUBLE_BUF_EN for both bench and RTL to exercise the hold-register build.
module tb_block_byte_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cycle;
    int   acceptCycle;
    int   hsCount;
    int   firstHs;
    int   lastHs;
    logic [12:0] exp_q[$];

    localparam logic [127:0] P1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] P2 = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] P3 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    block_byte_sequencer_if bus ();

    block_byte_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Hand-derived byte tables: P1 is i*0x11, P2 its complement, P3 has {i, 15-i}.
    function automatic logic [7:0] patByte(input int kind, input int i);
        logic [3:0] n;
        n = i[3:0];
        case (kind)
            1:       return {n, n};
            2:       return {~n, ~n};
            default: return {n, ~n};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Offers one block, queues its 16 expected bytes, returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [127:0] blk, input int kind);
        int guard;
        guard = 0;
        bus.in_block = blk;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back({(i == 15), 4'(i), patByte(kind, i)});
            end
        end
        @(posedge clk);
        #1;
        acceptCycle  = cycle;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitIdx(input logic [3:0] target);
        int guard;
        guard = 0;
        while (!(bus.out_valid && bus.out_idx == target) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("[TB] FAIL idx_timeout: got idx=%0d expected %0d", bus.out_idx, target);
        end
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 400) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compares every transferred byte against the queue and checks stall stability.
    initial begin
        logic        held;
        logic [12:0] seen;
        logic [12:0] prev;
        logic [12:0] want;
        held = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                seen = {bus.out_last, bus.out_idx, bus.out_byte};
                if (held && bus.out_valid) begin
                    checkOutput("stall_hold", seen, prev);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (hsCount == 0) firstHs = cycle;
                    lastHs = cycle;
                    hsCount++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_byte: got %0h expected none", seen);
                    end else begin
                        want = exp_q.pop_front();
                        checkOutput("byte", seen, want);
                    end
                end
                held = bus.out_valid && !bus.out_ready;
                prev = seen;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        logic [3:0] bp;
        total = 0;
        bad = 0;
        cycle = 0;
        hsCount = 0;
        firstHs = 0;
        lastHs = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_block = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_last", bus.out_last, 0);
        checkOutput("rst_out_idx", bus.out_idx, 0);
        checkOutput("rst_out_byte", bus.out_byte, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("release_in_ready", bus.in_ready, 1);

        $display("[TB] single block");
        bus.out_ready = 1'b1;
        applyStimulus(P1, 1);
        checkOutput("latency_valid", bus.out_valid, 1);
        checkOutput("latency_idx", bus.out_idx, 0);
        checkOutput("latency_byte", bus.out_byte, 8'h00);
        waitDrain();
        checkOutput("done_busy", bus.busy, 0);
        checkOutput("done_in_ready", bus.in_ready, 1);

        $display("[TB] back-to-back acceptance spacing");
        applyStimulus(P1, 1);
        c1 = acceptCycle;
        applyStimulus(P2, 2);
`ifdef SEQ_DOUBLE_BUF_EN
        checkOutput("accept_gap", acceptCycle - c1, 1);
`else
        checkOutput("accept_gap", acceptCycle - c1, 17);
`endif
        waitDrain();

        $display("[TB] backpressure 1,0,0,1");
        bp = 4'b1001;
        applyStimulus(P3, 3);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            bus.out_ready = bp[k % 4];
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        waitDrain();

        $display("[TB] flush at idx 5");
        applyStimulus(P1, 1);
        waitIdx(4'd5);
        bus.flush = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("flush_out_valid", bus.out_valid, 0);
        checkOutput("flush_in_ready", bus.in_ready, 1);
        checkOutput("flush_idx", bus.out_idx, 0);
        checkOutput("flush_busy", bus.busy, 0);
        applyStimulus(P2, 2);
        checkOutput("after_flush_byte0", bus.out_byte, 8'hff);
        waitDrain();

        $display("[TB] async reset at idx 9");
        applyStimulus(P3, 3);
        waitIdx(4'd9);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_out_idx", bus.out_idx, 0);
        checkOutput("midrst_out_byte", bus.out_byte, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("postrst_in_ready", bus.in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("postrst_out_valid", bus.out_valid, 0);

        $display("[TB] flush colliding with input handshake");
        bus.in_block = P1;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        #1;
        checkOutput("collide_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        checkOutput("collide_out_valid", bus.out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("collide_still_idle", bus.out_valid, 0);
        checkOutput("collide_busy", bus.busy, 0);

`ifdef SEQ_DOUBLE_BUF_EN
        $display("[TB] double buffer: three blocks without bubbles");
        hsCount = 0;
        applyStimulus(P1, 1);
        applyStimulus(P2, 2);
        checkOutput("hold_full_in_ready", bus.in_ready, 0);
        applyStimulus(P3, 3);
        waitDrain();
        checkOutput("stream_count", hsCount, 48);
        checkOutput("stream_span", lastHs - firstHs, 47);

        $display("[TB] double buffer: stall on last byte before switch");
        applyStimulus(P1, 1);
        applyStimulus(P2, 2);
        waitIdx(4'd15);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("stall_last_idx", bus.out_idx, 15);
        checkOutput("stall_last_byte", bus.out_byte, 8'hff);
        checkOutput("stall_last_flag", bus.out_last, 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("switch_idx", bus.out_idx, 0);
        checkOutput("switch_valid", bus.out_valid, 1);
        waitDrain();
`endif

        waitDrain();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
